// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch / issue unit with a small writable program memory.
// The program is loaded word by word while idle, then a run pulse starts
// issuing instructions from address 0, one per cycle, until an opcode of
// 4'hF is issued, which parks the unit in HALT. A further run pulse restarts
// the program from address 0.
//
// Instruction word layout: opcode[15:12] | operands[11:4] | imm[3:0]
// Branches are resolved from the issued instruction: a taken branch
// (branch & zero) adds the sign-extended imm to pc; otherwise pc+1.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset (does not clear memory)
//   load_en    in   program write strobe (honoured only while IDLE)
//   load_addr  in   program write address         [PC_W]
//   load_data  in   program write word            [16]
//   run        in   start pulse (IDLE / HALT only)
//   stall      in   hold the current issue
//   branch     in   branch decode of the issued opcode
//   zero       in   ALU zero flag for the issued instruction
//   instr      out  issued instruction word, registered  [16]
//   opcode     out  instr[15:12]                         [4]
//   pc         out  address of the issued instruction    [PC_W]
//   valid      out  instr holds a live instruction
//   halted     out  HALT state indicator
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset; program may be loaded; waiting for run
// RUN    | issuing one instruction per cycle unless stalled
// HALT   | HALT opcode was issued; instr/pc hold it; waiting for run
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_addr,
  input  logic [15:0]     load_data,
  input  logic            run,
  input  logic            stall,
  input  logic            branch,
  input  logic            zero,
  output logic [15:0]     instr,
  output logic [3:0]      opcode,
  output logic [PC_W-1:0] pc,
  output logic            valid,
  output logic            halted
);

  localparam int         DEPTH   = 2 ** PC_W;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     mem [DEPTH];
  logic [15:0]     instr_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] fetch_addr;
  logic [PC_W-1:0] br_offset;
  logic [15:0]     rd_word;
  logic            load_we;
  logic            br_taken;

  // imm sign-extended (or truncated) to the pc width; additions wrap mod 2**PC_W
  assign br_offset = PC_W'({{PC_W{instr[3]}}, instr[3:0]});
  assign br_taken  = valid & branch & zero;

  // A write and a fetch can land on the same edge (load_en with run in
  // IDLE); forward the write data so the fetch sees post-write contents.
  assign rd_word = (load_we && (load_addr == fetch_addr)) ? load_data
                                                          : mem[fetch_addr];

  always_comb begin
    state_nxt  = state;
    instr_nxt  = instr;
    pc_nxt     = pc;
    fetch_addr = '0;
    load_we    = 1'b0;

    case (state)
      IDLE: begin
        load_we = load_en;
        if (run) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          instr_nxt = rd_word;
        end
      end

      RUN: begin
        if (!stall) begin
          if (opcode == OP_HALT) begin
            state_nxt = HALT;
          end else begin
            fetch_addr = br_taken ? (pc + br_offset) : (pc + PC_W'(1));
            pc_nxt     = fetch_addr;
            instr_nxt  = rd_word;
          end
        end
      end

      HALT: begin
        if (run) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          instr_nxt = rd_word;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      instr <= 16'h0000;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      instr <= instr_nxt;
      pc    <= pc_nxt;
    end
  end

  // Program memory has no reset; reset only blocks a coincident write.
  always_ff @(posedge clk) begin
    if (load_we && !rst) begin
      mem[load_addr] <= load_data;
    end
  end

  assign opcode = instr[15:12];
  assign valid  = (state == RUN);
  assign halted = (state == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int PC_W = 4;

  logic            clk;
  logic            rst;
  logic            load_en;
  logic [PC_W-1:0] load_addr;
  logic [15:0]     load_data;
  logic            run;
  logic            stall;
  logic            branch;
  logic            zero;
  logic [15:0]     instr;
  logic [3:0]      opcode;
  logic [PC_W-1:0] pc;
  logic            valid;
  logic            halted;

  instr_fetch #(.PC_W(PC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .run       (run),
    .stall     (stall),
    .branch    (branch),
    .zero      (zero),
    .instr     (instr),
    .opcode    (opcode),
    .pc        (pc),
    .valid     (valid),
    .halted    (halted)
  );

  typedef struct {
    logic            rst;
    logic            load_en;
    logic [PC_W-1:0] load_addr;
    logic [15:0]     load_data;
    logic            run;
    logic            stall;
    logic            branch;
    logic            zero;
    logic [15:0]     e_instr;
    logic [PC_W-1:0] e_pc;
    logic            e_valid;
    logic            e_halted;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   idx_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic r, input logic le, input logic [PC_W-1:0] la,
                              input logic [15:0] ld, input logic ru, input logic st,
                              input logic br, input logic ze, input logic [15:0] ei,
                              input logic [PC_W-1:0] ep, input logic ev, input logic eh);
    vec_t v;
    v.rst = r; v.load_en = le; v.load_addr = la; v.load_data = ld;
    v.run = ru; v.stall = st; v.branch = br; v.zero = ze;
    v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_halted = eh;
    return v;
  endfunction

  // Scoreboard: one expectation per driven cycle, checked #1 after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      vec_t e;
      int   k;
      logic [25:0] got, want;
      e    = exp_q.pop_front();
      k    = idx_q.pop_front();
      got  = {instr, opcode, pc, valid, halted};
      want = {e.e_instr, e.e_instr[15:12], e.e_pc, e.e_valid, e.e_halted};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL step%0d got instr=%h pc=%0d valid=%b halted=%b opc=%h want instr=%h pc=%0d valid=%b halted=%b",
                 k, instr, pc, valid, halted, opcode,
                 e.e_instr, e.e_pc, e.e_valid, e.e_halted);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    run = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0;

    //             rst le la  ld       run st br ze   instr    pc v  h
    // basic program 1000,2000,F000 and halt
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h1000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h2000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 16'hF000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h1000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h2000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'hF000, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'hF000, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 16'hF000, 2, 0, 1));
    // load in HALT ignored, restart
    vecs.push_back(mk(0, 1, 0, 16'hABCD, 0, 0, 0, 0, 16'hF000, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h1000, 0, 1, 0));
    // load in RUN ignored
    vecs.push_back(mk(0, 1, 0, 16'hABCD, 0, 0, 0, 0, 16'h2000, 1, 1, 0));
    // stall 3 cycles at pc=1 with branch/zero toggling
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h2000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h2000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 1, 0, 16'h2000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'hF000, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'hF000, 2, 0, 1));
    // HALT -> run: mem[0] still 1000
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h1000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h2000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'hF000, 2, 1, 0));
    // reset mid-RUN at pc=2, with run/stall/load asserted
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h5555, 1, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h1000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h2000, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    // forward branch program
    vecs.push_back(mk(0, 1, 2, 16'h3000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 16'h4002, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 16'h1004, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 16'h1005, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h1000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h2000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h3000, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h4002, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h1005, 5, 1, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    // same branch not taken (zero=0)
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h1000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h2000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h3000, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h4002, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h1004, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h1005, 5, 1, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    // backward branch imm=-2 from pc=1 -> 15, then sequential wrap to 0
    vecs.push_back(mk(0, 1, 1,  16'h200E, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 15, 16'h700F, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h1000, 0,  1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h200E, 1,  1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h700F, 15, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h1000, 0,  1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h200E, 1,  1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h200E, 1,  1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h3000, 2,  1, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0,  0, 0));
    // load and run together: fetch sees the new word
    vecs.push_back(mk(0, 1, 0, 16'hABCD, 1, 0, 0, 0, 16'hABCD, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h200E, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'hABCD, 0, 1, 0));
    // reset while stalled
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      load_en   = vecs[i].load_en;
      load_addr = vecs[i].load_addr;
      load_data = vecs[i].load_data;
      run       = vecs[i].run;
      stall     = vecs[i].stall;
      branch    = vecs[i].branch;
      zero      = vecs[i].zero;
      exp_q.push_back(vecs[i]);
      idx_q.push_back(i);
    end

    @(negedge clk);
    rst = 1'b0; load_en = 1'b0; run = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter PC_W, default 4, meaning PC width; instruction memory depth is 2**PC_W words.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have port load_en  input  1  program write strobe.
REQ-005 The block SHALL have port load_addr  input  PC_W  program write address.
REQ-006 The block SHALL have port load_data  input  16  program write word: opcode[15:12], operands[11:4], imm[3:0].
REQ-007 The block SHALL have port run  input  1  start pulse.
REQ-008 The block SHALL have port stall  input  1  hold the current issue.
REQ-009 The block SHALL have port branch  input  1  Branch decode of the issued opcode, from the control unit.
REQ-010 The block SHALL have port zero  input  1  ALU zero flag for the issued instruction.
REQ-011 The block SHALL have port instr  output  16  issued instruction word, registered.
REQ-012 The block SHALL have port opcode  output  4  equal to instr[15:12], feeding the control unit.
REQ-013 The block SHALL have port pc  output  PC_W  address of the issued instruction.
REQ-014 The block SHALL have port valid  output  1  instr holds a live instruction.
REQ-015 The block SHALL have port halted  output  1  HALT state indicator.

Function
REQ-016 The block SHALL implement a three-state FSM with states IDLE, RUN and HALT.
REQ-017 IDLE SHALL transition to RUN on run=1, with the fetch address set to 0.
REQ-018 In IDLE, load_en=1 SHALL write mem[load_addr] <= load_data at the clock edge; load_en SHALL be ignored in RUN and HALT.
REQ-019 The first instruction SHALL appear one cycle after run is sampled: instr=mem[0], pc=0, valid=1.
REQ-020 In RUN with stall=0, each cycle SHALL issue the next instruction; next address = pc+sext(imm) when valid&branch&zero, otherwise pc+1.
REQ-021 Branch target arithmetic SHALL be modulo 2**PC_W, with imm sign-extended 4-bit (-8..+7); sequential pc+1 SHALL wrap from 2**PC_W-1 to 0.
REQ-022 While stall=1, instr, pc, valid and the FSM state SHALL hold, and branch and zero SHALL be ignored.
REQ-023 When the issued opcode is 4'b1111 and stall=0, the FSM SHALL go to HALT at the next edge, with valid=0 and halted=1 from that edge; instr and pc SHALL hold the HALT instruction.
REQ-024 In HALT, run=1 SHALL restart execution exactly as in REQ-017/REQ-019, with halted=0.
REQ-025 run SHALL be ignored while in RUN.
REQ-026 If load_en and run are both 1 in IDLE, the write SHALL occur and fetch SHALL use the post-write memory contents.
REQ-027 Memory SHALL be read combinationally at the fetch address; instr SHALL be the only registered copy.

Reset
REQ-028 rst=1 SHALL force IDLE, fetch address 0, instr=16'h0000, pc=0, valid=0 and halted=0 at the next edge, from any state including mid-RUN and during stall.
REQ-029 rst SHALL NOT clear instruction memory contents.
REQ-030 rst SHALL take priority over run, load_en and stall.

Verification
REQ-031 Load 0:16'h1000, 1:16'h2000, 2:16'hF000, then pulse run -> instr/pc sequence 16'h1000/0, 16'h2000/1, 16'hF000/2 on consecutive cycles, then valid=0 and halted=1.
REQ-032 Branch: mem[3]=16'h4002, with branch=1 and zero=1 while pc=3 -> next pc=5; repeat with zero=0 -> next pc=4.
REQ-033 Backward branch and wrap: mem[1] imm=4'hE (-2), taken -> next pc=15; mem[15] non-branch -> next pc=0.
REQ-034 Stall: assert stall for 3 cycles while pc=1 -> instr, pc and valid are unchanged for 3 cycles, and branch/zero toggles have no effect; the pc=2 instruction issues on the cycle after stall drops.
REQ-035 Reset mid-RUN at pc=2 -> next cycle state IDLE, valid=0, pc=0; a subsequent run re-issues the loaded mem[0] unchanged.
REQ-036 load_en=1 during RUN with load_addr=0 and load_data=16'hABCD -> mem[0] is unchanged, checked after HALT followed by run.
